// File: rtl/input_buffer.sv
// 16-entry synchronous FIFO at the front of the hardware sorter.
// Optional zero-latency empty bypass is compiled in with `define INPUT_BUFFER_BYPASS_EN.
module input_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic [DATA_W-1:0] din,
  input  logic              i_enq,
  input  logic              clk,
  input  logic              rst,
  input  logic              full,
  output logic [DATA_W-1:0] dout,
  output logic              i_full,
  output logic [CNT_W-1:0]  ecnt,
  output logic              enq
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              empty;
  logic              bypass;
  logic              push;
  logic              pop;

  assign empty  = (ecnt == '0);
  assign i_full = (ecnt == CNT_W'(DEPTH));

`ifdef INPUT_BUFFER_BYPASS_EN
  // An empty buffer hands the incoming word straight through without storing it.
  assign bypass = empty & i_enq & ~full;
`else
  assign bypass = 1'b0;
`endif

  assign push = i_enq & ~i_full & ~bypass;
  assign pop  = ~empty & ~full;
  assign enq  = pop | bypass;
  assign dout = bypass ? din : mem[rd_ptr];

  // Storage array holds data only; pointers decide validity, so no reset here.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ecnt   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   ecnt <= ecnt + CNT_W'(1);
        2'b01:   ecnt <= ecnt - CNT_W'(1);
        default: ecnt <= ecnt;
      endcase
    end
  end

endmodule

// File: tb/tb_input_buffer.sv
// Scoreboard bench for input_buffer: expected words queue on accepted pushes, pop on enq.
module tb_input_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic [DATA_W-1:0] din;
  logic              i_enq;
  logic              clk;
  logic              rst;
  logic              full;
  logic [DATA_W-1:0] dout;
  logic              i_full;
  logic [CNT_W-1:0]  ecnt;
  logic              enq;

  int nvec = 0;
  int nerr = 0;
  logic [DATA_W-1:0] sb [$];

  input_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .din(din), .i_enq(i_enq), .clk(clk), .rst(rst), .full(full),
    .dout(dout), .i_full(i_full), .ecnt(ecnt), .enq(enq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Check outputs mid-cycle against the model, then advance one clock and update the model.
  task automatic step();
    bit exp_enq;
    bit byp;
    bit acc;
    int sz;
    @(negedge clk);
    sz  = sb.size();
    byp = 1'b0;
`ifdef INPUT_BUFFER_BYPASS_EN
    byp = (sz == 0) && i_enq && !full;
`endif
    exp_enq = ((sz != 0) && !full) || byp;
    acc     = i_enq && (sz < DEPTH) && !byp;
    chk("enq", {31'd0, enq}, {31'd0, exp_enq});
    chk("ecnt", {27'd0, ecnt}, sz);
    chk("i_full", {31'd0, i_full}, {31'd0, sz == DEPTH});
    if (enq && exp_enq) begin
      if (byp) chk("dout_bypass", dout, din);
      else     chk("dout", dout, sb[0]);
    end
    @(posedge clk);
    if (rst) begin
      sb.delete();
    end else begin
      if (exp_enq && !byp) void'(sb.pop_front());
      if (acc) sb.push_back(din);
    end
    #1;
  endtask

  initial begin
    int k;
    int budget;
    din = '0; i_enq = 1'b0; full = 1'b0; rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Arbitrary traffic, then a one-edge reset mid-operation
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_enq = 1'b1; din = 32'(1000 + i); step();
    end
    rst = 1'b1; step();
    rst = 1'b0; i_enq = 1'b0; full = 1'b0;
    step();
    chk("post_reset_ecnt", {27'd0, ecnt}, 32'd0);

    // Single word
    i_enq = 1'b1; din = 32'd4532; step();
    i_enq = 1'b0; din = 32'd0;
    step(); step(); step();

    // Streaming alternate values
    for (int i = 0; i < 20; i++) begin
      i_enq = 1'b1; din = (i % 2 == 0) ? 32'd32651 : 32'd65432; step();
    end
    i_enq = 1'b0;
    step(); step();

    // Backpressure fill: 17 distinct words, last must be dropped
    full = 1'b1;
    for (int i = 0; i < 17; i++) begin
      i_enq = 1'b1; din = 32'(500 + i); step();
    end
    i_enq = 1'b0;
    step();
    chk("fill_i_full", {31'd0, i_full}, 32'd1);
    chk("fill_ecnt", {27'd0, ecnt}, 32'd16);
    full = 1'b0;
    for (int i = 0; i < 18; i++) step();

    // Wrap: 0..39 with intermittent downstream full
    k = 0;
    budget = 0;
    while (k < 40 && budget < 400) begin
      full  = (budget % 3 == 1) || (budget % 7 == 0);
      i_enq = (budget % 5 != 4);
      din   = 32'(k);
      if (i_enq && !i_full) begin
`ifdef INPUT_BUFFER_BYPASS_EN
        k++;
`else
        k++;
`endif
      end
      step();
      budget++;
    end
    chk("wrap_all_pushed", k, 32'd40);
    i_enq = 1'b0; full = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("wrap_drained", {27'd0, ecnt}, 32'd0);

    // Empty buffer with a word arriving: bypass when compiled in, stored otherwise
    i_enq = 1'b1; din = 32'd7; full = 1'b0; step();
    i_enq = 1'b0; step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
